// File: rtl/ovc_allocator.sv
// Output-VC allocator and per-OVC credit tracker for one router output port.
// Latency: grant/grant_ovc registered, 1 cycle after req; credits/busy update on the edge.
// Backpressure: no grant while every OVC is busy; requesters hold req until granted.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   req / grant        per-input-VC request and one-hot 1-cycle grant pulse
//   grant_ovc          OVC index assigned alongside grant
//   send_valid/_ovc/_tail  departing flit: consumes a credit, tail frees its OVC
//   credit_in          per-OVC credit return from downstream
//   credit_out         packed credit counts, OVC k at [k*CW +: CW]
//   ovc_busy           OVC allocated to a packet in flight
//   err                sticky: send with zero credits or credit overflow
module ovc_allocator #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_OVC  = 4,
    parameter int VC_DEPTH = 4,
    parameter int OVC_W    = 2,
    parameter int CW       = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    output logic [NUM_REQ-1:0]     grant,
    output logic [OVC_W-1:0]       grant_ovc,
    input  logic                   send_valid,
    input  logic [OVC_W-1:0]       send_ovc,
    input  logic                   send_tail,
    input  logic [NUM_OVC-1:0]     credit_in,
    output logic [NUM_OVC*CW-1:0]  credit_out,
    output logic [NUM_OVC-1:0]     ovc_busy,
    output logic                   err
);
    localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [REQ_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [REQ_W-1:0]   win_idx;
    logic               free_found;
    logic [OVC_W-1:0]   free_idx;
    logic               do_grant;
    logic [CW-1:0]      credit [NUM_OVC];

    // grant is last cycle's grant: masking it stops a second grant to a
    // requester whose req is still visible the cycle it is granted.
    always_comb begin
        eligible = req & ~grant;
    end

    // Lowest-index free OVC; scanning downward leaves the lowest one last.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int k = NUM_OVC - 1; k >= 0; k--) begin
            if (!ovc_busy[k]) begin
                free_found = 1'b1;
                free_idx   = OVC_W'(k);
            end
        end
    end

    // Round-robin: first eligible requester at or after the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            int cand;
            cand = (int'(rr_ptr) + off) % NUM_REQ;
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = REQ_W'(cand);
            end
        end
    end

    assign do_grant = win_found && free_found;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant     <= '0;
            grant_ovc <= '0;
            rr_ptr    <= '0;
        end else begin
            grant <= '0;
            if (do_grant) begin
                grant[win_idx] <= 1'b1;
                grant_ovc      <= free_idx;
                rr_ptr         <= REQ_W'((int'(win_idx) + 1) % NUM_REQ);
            end
        end
    end

    // Release before allocate: the allocated OVC was free this cycle, so a
    // tail on it cannot cancel the new allocation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovc_busy <= '0;
        end else begin
            for (int k = 0; k < NUM_OVC; k++) begin
                if (send_valid && send_tail && send_ovc == OVC_W'(k))
                    ovc_busy[k] <= 1'b0;
                if (do_grant && free_idx == OVC_W'(k))
                    ovc_busy[k] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_OVC; k++) credit[k] <= CW'(VC_DEPTH);
            err <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_OVC; k++) begin
                logic dec;
                logic inc;
                dec = send_valid && (send_ovc == OVC_W'(k));
                inc = credit_in[k];
                if (dec && !inc) begin
                    if (credit[k] == '0) err <= 1'b1;
                    else                 credit[k] <= credit[k] - 1'b1;
                end else if (inc && !dec) begin
                    if (credit[k] == CW'(VC_DEPTH)) err <= 1'b1;
                    else                            credit[k] <= credit[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        credit_out = '0;
        for (int k = 0; k < NUM_OVC; k++) credit_out[k*CW +: CW] = credit[k];
    end
endmodule
